// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and widths for the ALU arbiter
package alu_arb_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Opcodes understood by the shared ALU; the arbiter passes them through untouched.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  // Walk from farthest to nearest after i_last so the nearest valid requester wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [ID_W-1:0] w_idx;
      w_idx = ID_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between requesters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_b,
  input  logic [NUM_REQ-1:0][OP_W-1:0]     req_op,
  output logic [DATA_W-1:0]                alu_a,
  output logic [DATA_W-1:0]                alu_b,
  output logic [OP_W-1:0]                  alu_op,
  input  logic [DATA_W-1:0]                alu_y,
  input  logic                             alu_co,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DATA_W-1:0]                rsp_y,
  output logic                             rsp_co,
  output logic                             busy,
  output logic [15:0]                      ops_done
);

  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

  arb_state_t          r_state;
  arb_state_t          w_next;
  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_y;
  logic                r_rsp_co;
  logic [15:0]         r_ops_done;
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and the grant strobe; grant is masked while reset is held.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid && reset) begin
          req_ready[w_pick_idx] = 1'b1;
          w_next = EXEC;
        end
      end
      EXEC: if (r_cnt == CNT_LAST) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on grant, result capture at end of EXEC, bookkeeping on response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_y      <= '0;
      r_rsp_co     <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_alu_a  <= req_a[w_pick_idx];
            r_alu_b  <= req_b[w_pick_idx];
            r_alu_op <= req_op[w_pick_idx];
            r_id     <= w_pick_idx;
            r_cnt    <= '0;
          end
        end
        EXEC: begin
          if (r_cnt == CNT_LAST) begin
            r_rsp_y     <= alu_y;
            r_rsp_co    <= alu_co;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_last_grant <= r_id;
            r_ops_done   <= r_ops_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign rsp_co    = r_rsp_co;
  assign busy      = (r_state != IDLE);
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][7:0] req_a, req_b;
  logic [3:0][3:0] req_op;
  logic [3:0] v1, v0, v3, rr1, rr0, rr3;
  logic rsp_ready;

  logic [7:0] a1, b1, y1, a0, b0, y0, a3, b3, y3;
  logic [3:0] op1, op0, op3;
  logic co1, co0, co3;
  logic rv1, rv0, rv3, rc1, rc0, rc3, bz1, bz0, bz3;
  logic [1:0] id1, id0, id3;
  logic [7:0] ry1, ry0, ry3;
  logic [15:0] od1, od0, od3;

  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] p3 [3];
  assign {co0, y0} = alu_f(a0, b0, op0);
  always @(posedge clk) {co1, y1} <= alu_f(a1, b1, op1);
  always @(posedge clk) begin
    p3[0] <= alu_f(a3, b3, op3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {co3, y3} = p3[2];

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rr1),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_y(y1), .alu_co(co1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(id1), .rsp_y(ry1), .rsp_co(rc1),
    .busy(bz1), .ops_done(od1));

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rr0),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_y(y0), .alu_co(co0),
    .rsp_valid(rv0), .rsp_ready(1'b1), .rsp_id(id0), .rsp_y(ry0), .rsp_co(rc0),
    .busy(bz0), .ops_done(od0));

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rr3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_y(y3), .alu_co(co3),
    .rsp_valid(rv3), .rsp_ready(1'b1), .rsp_id(id3), .rsp_y(ry3), .rsp_co(rc3),
    .busy(bz3), .ops_done(od3));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    v1 = '0; v0 = '0; v3 = '0; rsp_ready = 1'b1;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bz1 === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    v1 = 4'hF; v0 = '0; v3 = '0; rsp_ready = 1'b1;
    reset = 1'b0;
    tick(); #1;
    checks++; if (rr1 !== 4'h0) begin errors++; $display("FAIL reset_req_ready got=%h exp=0", rr1); end
    checks++; if ({a1, b1, op1} !== 20'h0) begin errors++; $display("FAIL reset_alu got=%h exp=0", {a1, b1, op1}); end
    checks++; if ({rv1, id1, ry1, rc1, bz1} !== 13'h0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {rv1, id1, ry1, rc1, bz1}); end
    checks++; if (od1 !== 16'h0) begin errors++; $display("FAIL reset_ops_done got=%h exp=0", od1); end
    v1 = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_a[2] = 8'hF0; req_b[2] = 8'h20; req_op[2] = OP_ADD;
    v1 = 4'b0100; #1;
    checks++; if (rr1 !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", rr1); end
    tick(); v1 = '0; #1;
    checks++; if ({bz1, rv1, a1, b1} !== {1'b1, 1'b0, 8'hF0, 8'h20}) begin errors++; $display("FAIL single_exec got=%h exp=%h", {bz1, rv1, a1, b1}, {1'b1, 1'b0, 8'hF0, 8'h20}); end
    tick(); #1;
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL single_early_rsp got=%b exp=0", rv1); end
    tick(); #1;
    checks++; if ({rv1, id1, ry1, rc1} !== {1'b1, 2'd2, 8'h10, 1'b1}) begin errors++; $display("FAIL single_rsp got=%h exp=%h", {rv1, id1, ry1, rc1}, {1'b1, 2'd2, 8'h10, 1'b1}); end
    tick(); #1;
    checks++; if ({rv1, bz1, od1} !== {1'b0, 1'b0, 16'd1}) begin errors++; $display("FAIL single_done got=%h exp=%h", {rv1, bz1, od1}, {1'b0, 1'b0, 16'd1}); end
  endtask

  task automatic test_round_robin();
    int ng;
    int gord [5];
    int last_cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 8'h10 * i[7:0] + 8'h01; req_b[i] = 8'h01; req_op[i] = OP_ADD;
    end
    v1 = 4'hF; ng = 0; last_cyc = -10;
    for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
      #1;
      if (rr1 !== 4'h0) begin
        checks++; if (bz1 !== 1'b0 || !$onehot(rr1)) begin errors++; $display("FAIL rr_grant_while_busy busy=%b ready=%b exp busy=0 onehot", bz1, rr1); end
        checks++; if (ng > 0 && cyc - last_cyc !== 4) begin errors++; $display("FAIL rr_interval got=%0d exp=4", cyc - last_cyc); end
        for (int k = 0; k < 4; k++) if (rr1[k]) gord[ng] = k;
        last_cyc = cyc;
        ng++;
      end
      if (rv1 === 1'b1) begin
        checks++; if (ry1 !== req_a[id1] + 8'h01) begin errors++; $display("FAIL rr_rsp_y id=%0d got=%h exp=%h", id1, ry1, req_a[id1] + 8'h01); end
      end
      tick();
    end
    checks++; if (ng !== 5) begin errors++; $display("FAIL rr_grant_count got=%0d exp=5", ng); end
    for (int k = 0; k < 5 && k < ng; k++) begin
      checks++; if (gord[k] !== k % 4) begin errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, gord[k], k % 4); end
    end
    v1 = '0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain got=busy exp=idle"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    do_reset();
    req_a[1] = 8'h33; req_b[1] = 8'h44; req_op[1] = OP_OR;
    req_a[3] = 8'h05; req_b[3] = 8'h06; req_op[3] = OP_XOR;
    rsp_ready = 1'b0;
    v1 = 4'b0010; #1;
    checks++; if (rr1 !== 4'b0010) begin errors++; $display("FAIL bp_grant got=%b exp=0010", rr1); end
    tick(); v1 = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (rv1 === 1'b1) seen = 1'b1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_timeout got=no_rsp exp=rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rv1, id1, ry1, rc1, a1, b1, op1, rr1} !== {1'b1, 2'd1, 8'h77, 1'b0, 8'h33, 8'h44, 4'(OP_OR), 4'h0}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {rv1, id1, ry1, rc1, a1, b1, op1, rr1},
                           {1'b1, 2'd1, 8'h77, 1'b0, 8'h33, 8'h44, 4'(OP_OR), 4'h0});
      end
      tick();
    end
    rsp_ready = 1'b1; #1;
    checks++; if (rr1 !== 4'h0) begin errors++; $display("FAIL bp_ready_in_resp got=%b exp=0000", rr1); end
    tick(); #1;
    checks++; if ({rr1, rv1, od1} !== {4'b1000, 1'b0, 16'd1}) begin errors++; $display("FAIL bp_next_grant got=%h exp=%h", {rr1, rv1, od1}, {4'b1000, 1'b0, 16'd1}); end
    tick(); v1 = '0;
    wait_idle(ok);
    checks++; if (!ok || od1 !== 16'd2) begin errors++; $display("FAIL bp_drain ok=%b ops=%0d exp ok=1 ops=2", ok, od1); end
  endtask

  task automatic test_latency();
    int ex0, ex3;
    bit got0, got3;
    logic [8:0] r0, r3;
    do_reset();
    req_a[0] = 8'h10; req_b[0] = 8'h20; req_op[0] = OP_SUB;
    v0 = 4'b0001; v3 = 4'b0001;
    ex0 = 0; ex3 = 0; got0 = 1'b0; got3 = 1'b0; r0 = '0; r3 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin v0 = '0; v3 = '0; end
      #1;
      if (bz0 === 1'b1 && rv0 === 1'b0) ex0++;
      if (bz3 === 1'b1 && rv3 === 1'b0) ex3++;
      if (rv0 === 1'b1) begin got0 = 1'b1; r0 = {rc0, ry0}; end
      if (rv3 === 1'b1) begin got3 = 1'b1; r3 = {rc3, ry3}; end
    end
    checks++; if (ex0 !== 1) begin errors++; $display("FAIL lat0_exec_cycles got=%0d exp=1", ex0); end
    checks++; if (ex3 !== 4) begin errors++; $display("FAIL lat3_exec_cycles got=%0d exp=4", ex3); end
    checks++; if (!got0 || r0 !== 9'h1F0) begin errors++; $display("FAIL lat0_result got=%h exp=1f0", r0); end
    checks++; if (!got3 || r3 !== 9'h1F0) begin errors++; $display("FAIL lat3_result got=%h exp=1f0", r3); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    req_a[2] = 8'hAA; req_b[2] = 8'h55; req_op[2] = OP_AND;
    req_a[0] = 8'h07; req_b[0] = 8'h08; req_op[0] = OP_ADD;
    v1 = 4'b0100;
    tick(); v1 = 4'b1001; #1;
    checks++; if (bz1 !== 1'b1) begin errors++; $display("FAIL mid_in_exec got=%b exp=1", bz1); end
    reset = 1'b0; #1;
    checks++; if ({bz1, rv1, rr1, a1, b1, op1, od1} !== 41'h0) begin errors++; $display("FAIL mid_async_clear got=%h exp=0", {bz1, rv1, rr1, a1, b1, op1, od1}); end
    tick(); #1;
    checks++; if ({rv1, rr1} !== 5'h0) begin errors++; $display("FAIL mid_held got=%h exp=0", {rv1, rr1}); end
    reset = 1'b1; #1;
    checks++; if (rr1 !== 4'b0001) begin errors++; $display("FAIL mid_first_prio got=%b exp=0001", rr1); end
    tick(); v1 = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (rv1 === 1'b1) seen = 1'b1; else tick();
    end
    checks++; if (!seen || {id1, ry1} !== {2'd0, 8'h0F}) begin errors++; $display("FAIL mid_rsp seen=%b got=%h exp=00f", seen, {id1, ry1}); end
    tick();
  endtask

  task automatic test_ops_wrap();
    bit ok;
    do_reset();
    force dut.r_ops_done = 16'hFFFF;
    tick();
    release dut.r_ops_done;
    #1;
    checks++; if (od1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", od1); end
    req_a[1] = 8'h01; req_b[1] = 8'h02; req_op[1] = OP_ADD;
    v1 = 4'b0010;
    tick(); v1 = '0;
    wait_idle(ok);
    checks++; if (!ok || od1 !== 16'h0000) begin errors++; $display("FAIL wrap ok=%b got=%h exp=0000", ok, od1); end
  endtask

  initial begin
    req_a = '0; req_b = '0; req_op = '0;
    v1 = '0; v0 = '0; v3 = '0; rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_ops_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
